// File: rtl/arcade_output_scheduler_if.sv
// Bundle between the arcade top level and the output scheduler: timing strobes,
// menu controls, menu/game sources and the scheduled VGA/PMOD outputs.
interface arcade_output_scheduler_if #(
  parameter int NUM_GAMES = 5
);
  logic                      pix_en;
  logic                      frame_start;
  logic                      up_p;
  logic                      down_p;
  logic                      enter_p;
  logic                      exit_p;
  logic [11:0]               menu_rgb;
  logic [12*NUM_GAMES-1:0]   game_rgb;
  logic [2:0]                menu_aud;
  logic [3*NUM_GAMES-1:0]    game_aud;
  logic [11:0]               rgb_out;
  logic [2:0]                aud_out;
  logic [2:0]                cursor;
  logic [2:0]                active_game;
  logic                      in_game;
  logic [NUM_GAMES-1:0]      game_rst;

  modport master (
    output pix_en, frame_start, up_p, down_p, enter_p, exit_p,
    output menu_rgb, game_rgb, menu_aud, game_aud,
    input  rgb_out, aud_out, cursor, active_game, in_game, game_rst
  );

  modport slave (
    input  pix_en, frame_start, up_p, down_p, enter_p, exit_p,
    input  menu_rgb, game_rgb, menu_aud, game_aud,
    output rgb_out, aud_out, cursor, active_game, in_game, game_rst
  );
endinterface

// File: rtl/arcade_output_scheduler.sv
// Menu cursor, frame-aligned menu<->game switching with blanking, and the
// registered pixel/audio mux that drives the shared VGA and PMOD pins.
//
// state       | meaning
// MENU        | menu on outputs, cursor moves, enter starts a game
// BLANK_IN    | black/mute, counting frames before showing the game
// GAME        | selected game on outputs, exit returns to menu
// BLANK_OUT   | black/mute, counting frames before showing the menu
module arcade_output_scheduler #(
  parameter int NUM_GAMES    = 5,
  parameter int BLANK_FRAMES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  arcade_output_scheduler_if.slave bus
);

  typedef enum logic [1:0] {S_MENU, S_BLANK_IN, S_GAME, S_BLANK_OUT} state_t;

  localparam logic [2:0] CURSOR_LAST = 3'(NUM_GAMES - 1);
  localparam logic [3:0] BLANK_LAST  = 4'(BLANK_FRAMES - 1);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_cursor, w_cursor_nxt;
  logic [2:0]           r_active_game, w_active_game_nxt;
  logic [3:0]           r_blank_cnt, w_blank_cnt_nxt;
  logic [NUM_GAMES-1:0] r_game_rst, w_game_rst_nxt;
  logic [11:0]          r_rgb, w_rgb_sel, w_game_rgb;
  logic [2:0]           r_aud, w_aud_sel, w_game_aud;
  logic                 r_in_game;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_MENU;
      r_cursor      <= 3'd0;
      r_active_game <= 3'd0;
      r_blank_cnt   <= 4'd0;
      r_game_rst    <= '0;
      r_rgb         <= 12'h000;
      r_aud         <= 3'b000;
      r_in_game     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cursor      <= w_cursor_nxt;
      r_active_game <= w_active_game_nxt;
      r_blank_cnt   <= w_blank_cnt_nxt;
      r_game_rst    <= w_game_rst_nxt;
      // Driven from next state so in_game tracks the current state exactly
      r_in_game     <= (w_state_nxt == S_GAME);
      if (bus.pix_en) begin
        r_rgb <= w_rgb_sel;
        r_aud <= w_aud_sel;
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cursor_nxt      = r_cursor;
    w_active_game_nxt = r_active_game;
    w_blank_cnt_nxt   = r_blank_cnt;
    w_game_rst_nxt    = '0;
    case (r_state)
      S_MENU: begin
        if (bus.enter_p) begin
          w_state_nxt       = S_BLANK_IN;
          w_active_game_nxt = r_cursor;
          for (int i = 0; i < NUM_GAMES; i++)
            w_game_rst_nxt[i] = (r_cursor == 3'(i));
        end else if (bus.up_p && !bus.down_p && r_cursor != 3'd0) begin
          w_cursor_nxt = r_cursor - 3'd1;
        end else if (bus.down_p && !bus.up_p && r_cursor != CURSOR_LAST) begin
          w_cursor_nxt = r_cursor + 3'd1;
        end
      end
      S_BLANK_IN, S_BLANK_OUT: begin
        if (bus.frame_start) begin
          if (r_blank_cnt == BLANK_LAST) begin
            w_blank_cnt_nxt = 4'd0;
            w_state_nxt     = (r_state == S_BLANK_IN) ? S_GAME : S_MENU;
          end else begin
            w_blank_cnt_nxt = r_blank_cnt + 4'd1;
          end
        end
      end
      S_GAME: begin
        if (bus.exit_p) w_state_nxt = S_BLANK_OUT;
      end
      default: w_state_nxt = S_MENU;
    endcase
  end

  always_comb begin
    w_game_rgb = 12'h000;
    w_game_aud = 3'b000;
    for (int i = 0; i < NUM_GAMES; i++) begin
      if (r_active_game == 3'(i)) begin
        w_game_rgb = bus.game_rgb[12*i +: 12];
        w_game_aud = bus.game_aud[3*i +: 3];
      end
    end
    w_rgb_sel = 12'h000;
    w_aud_sel = 3'b000;
    case (r_state)
      S_MENU: begin
        w_rgb_sel = bus.menu_rgb;
        w_aud_sel = bus.menu_aud;
      end
      S_GAME: begin
        w_rgb_sel = w_game_rgb;
        w_aud_sel = w_game_aud;
      end
      default: begin
        w_rgb_sel = 12'h000;
        w_aud_sel = 3'b000;
      end
    endcase
  end

  assign bus.rgb_out     = r_rgb;
  assign bus.aud_out     = r_aud;
  assign bus.cursor      = r_cursor;
  assign bus.active_game = r_active_game;
  assign bus.in_game     = r_in_game;
  assign bus.game_rst    = r_game_rst;

endmodule

// File: tb/tb_arcade_output_scheduler.sv
// Directed bench for arcade_output_scheduler: cursor, enter/exit sequencing,
// blanking, source mux, reset behaviour and pix_en hold.
module tb_arcade_output_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  arcade_output_scheduler_if #(.NUM_GAMES(5)) bus ();

  arcade_output_scheduler #(.NUM_GAMES(5), .BLANK_FRAMES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] MENU_RGB = 12'hABC;
  localparam logic [2:0]  MENU_AUD = 3'd7;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic up, input logic down, input logic enter,
                      input logic ex, input logic frame);
    bus.up_p = up; bus.down_p = down; bus.enter_p = enter;
    bus.exit_p = ex; bus.frame_start = frame;
    tick();
    bus.up_p = 1'b0; bus.down_p = 1'b0; bus.enter_p = 1'b0;
    bus.exit_p = 1'b0; bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_tests++; if (bus.cursor !== 3'd0) begin n_fail++; $display("FAIL rst_cursor got %0d exp 0", bus.cursor); end
    n_tests++; if (bus.active_game !== 3'd0) begin n_fail++; $display("FAIL rst_active got %0d exp 0", bus.active_game); end
    n_tests++; if (bus.in_game !== 1'b0) begin n_fail++; $display("FAIL rst_in_game got %b exp 0", bus.in_game); end
    n_tests++; if (bus.game_rst !== 5'b0) begin n_fail++; $display("FAIL rst_game_rst got %b exp 00000", bus.game_rst); end
    n_tests++; if (bus.rgb_out !== 12'h000) begin n_fail++; $display("FAIL rst_rgb got %h exp 000", bus.rgb_out); end
    n_tests++; if (bus.aud_out !== 3'd0) begin n_fail++; $display("FAIL rst_aud got %0d exp 0", bus.aud_out); end
    rst = 1'b0;
    step(1, 0, 0, 0, 0);
    n_tests++; if (bus.cursor !== 3'd0) begin n_fail++; $display("FAIL up_sat0 got %0d exp 0", bus.cursor); end
    n_tests++; if (bus.rgb_out !== MENU_RGB) begin n_fail++; $display("FAIL menu_rgb got %h exp %h", bus.rgb_out, MENU_RGB); end
    n_tests++; if (bus.aud_out !== MENU_AUD) begin n_fail++; $display("FAIL menu_aud got %0d exp %0d", bus.aud_out, MENU_AUD); end
  endtask

  task automatic test_cursor();
    repeat (3) step(0, 1, 0, 0, 0);
    n_tests++; if (bus.cursor !== 3'd3) begin n_fail++; $display("FAIL down3 got %0d exp 3", bus.cursor); end
    step(1, 0, 0, 0, 0);
    n_tests++; if (bus.cursor !== 3'd2) begin n_fail++; $display("FAIL up1 got %0d exp 2", bus.cursor); end
    step(1, 1, 0, 0, 0);
    n_tests++; if (bus.cursor !== 3'd2) begin n_fail++; $display("FAIL up_down got %0d exp 2", bus.cursor); end
    repeat (6) step(0, 1, 0, 0, 0);
    n_tests++; if (bus.cursor !== 3'd4) begin n_fail++; $display("FAIL down_sat got %0d exp 4", bus.cursor); end
  endtask

  task automatic test_enter();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n_tests++; if (bus.game_rst !== 5'b01000) begin n_fail++; $display("FAIL enter_game_rst got %b exp 01000", bus.game_rst); end
    n_tests++; if (bus.active_game !== 3'd3) begin n_fail++; $display("FAIL enter_active got %0d exp 3", bus.active_game); end
    n_tests++; if (bus.cursor !== 3'd3) begin n_fail++; $display("FAIL enter_cursor got %0d exp 3", bus.cursor); end
    tick();
    n_tests++; if (bus.game_rst !== 5'b0) begin n_fail++; $display("FAIL game_rst_one_shot got %b exp 00000", bus.game_rst); end
    n_tests++; if (bus.rgb_out !== 12'h000) begin n_fail++; $display("FAIL blank_in_rgb got %h exp 000", bus.rgb_out); end
    n_tests++; if (bus.aud_out !== 3'd0) begin n_fail++; $display("FAIL blank_in_aud got %0d exp 0", bus.aud_out); end
    step(0, 0, 0, 0, 1);
    tick();
    n_tests++; if (bus.in_game !== 1'b0) begin n_fail++; $display("FAIL one_frame_in_game got %b exp 0", bus.in_game); end
    n_tests++; if (bus.rgb_out !== 12'h000) begin n_fail++; $display("FAIL one_frame_rgb got %h exp 000", bus.rgb_out); end
    step(0, 0, 0, 0, 1);
    n_tests++; if (bus.in_game !== 1'b1) begin n_fail++; $display("FAIL two_frame_in_game got %b exp 1", bus.in_game); end
    tick();
    n_tests++; if (bus.rgb_out !== 12'h444) begin n_fail++; $display("FAIL game3_rgb got %h exp 444", bus.rgb_out); end
    n_tests++; if (bus.aud_out !== 3'd4) begin n_fail++; $display("FAIL game3_aud got %0d exp 4", bus.aud_out); end
  endtask

  task automatic test_exit();
    step(0, 1, 0, 0, 0);
    n_tests++; if (bus.cursor !== 3'd3) begin n_fail++; $display("FAIL game_down_ignored got %0d exp 3", bus.cursor); end
    n_tests++; if (bus.in_game !== 1'b1) begin n_fail++; $display("FAIL game_hold got %b exp 1", bus.in_game); end
    step(1, 0, 0, 1, 0);
    n_tests++; if (bus.in_game !== 1'b0) begin n_fail++; $display("FAIL exit_in_game got %b exp 0", bus.in_game); end
    n_tests++; if (bus.cursor !== 3'd3) begin n_fail++; $display("FAIL exit_up_cursor got %0d exp 3", bus.cursor); end
    tick();
    n_tests++; if (bus.rgb_out !== 12'h000) begin n_fail++; $display("FAIL blank_out_rgb got %h exp 000", bus.rgb_out); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    n_tests++; if (bus.game_rst !== 5'b0) begin n_fail++; $display("FAIL blank_enter_ignored got %b exp 00000", bus.game_rst); end
    n_tests++; if (bus.rgb_out !== 12'h000) begin n_fail++; $display("FAIL blank_out_rgb2 got %h exp 000", bus.rgb_out); end
    step(0, 0, 0, 0, 1);
    tick();
    n_tests++; if (bus.in_game !== 1'b0) begin n_fail++; $display("FAIL back_menu_in_game got %b exp 0", bus.in_game); end
    n_tests++; if (bus.rgb_out !== MENU_RGB) begin n_fail++; $display("FAIL back_menu_rgb got %h exp %h", bus.rgb_out, MENU_RGB); end
    n_tests++; if (bus.aud_out !== MENU_AUD) begin n_fail++; $display("FAIL back_menu_aud got %0d exp %0d", bus.aud_out, MENU_AUD); end
    n_tests++; if (bus.active_game !== 3'd3) begin n_fail++; $display("FAIL back_menu_active got %0d exp 3", bus.active_game); end
  endtask

  task automatic test_enter_down();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    n_tests++; if (bus.active_game !== 3'd1) begin n_fail++; $display("FAIL enter_down_active got %0d exp 1", bus.active_game); end
    n_tests++; if (bus.cursor !== 3'd1) begin n_fail++; $display("FAIL enter_down_cursor got %0d exp 1", bus.cursor); end
    n_tests++; if (bus.game_rst !== 5'b00010) begin n_fail++; $display("FAIL enter_down_game_rst got %b exp 00010", bus.game_rst); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    tick();
    n_tests++; if (bus.rgb_out !== 12'h222) begin n_fail++; $display("FAIL game1_rgb got %h exp 222", bus.rgb_out); end
    n_tests++; if (bus.aud_out !== 3'd2) begin n_fail++; $display("FAIL game1_aud got %0d exp 2", bus.aud_out); end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    tick();
    n_tests++; if (bus.rgb_out !== MENU_RGB) begin n_fail++; $display("FAIL game1_exit_rgb got %h exp %h", bus.rgb_out, MENU_RGB); end
  endtask

  task automatic test_frame_on_enter_rst();
    step(0, 0, 1, 0, 1);
    n_tests++; if (bus.game_rst !== 5'b00010) begin n_fail++; $display("FAIL enter_frame_game_rst got %b exp 00010", bus.game_rst); end
    step(0, 0, 0, 0, 1);
    tick();
    n_tests++; if (bus.in_game !== 1'b0) begin n_fail++; $display("FAIL entry_frame_counted in_game got %b exp 0", bus.in_game); end
    n_tests++; if (bus.rgb_out !== 12'h000) begin n_fail++; $display("FAIL entry_frame_rgb got %h exp 000", bus.rgb_out); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (bus.cursor !== 3'd0) begin n_fail++; $display("FAIL midblank_rst_cursor got %0d exp 0", bus.cursor); end
    n_tests++; if (bus.game_rst !== 5'b0) begin n_fail++; $display("FAIL midblank_rst_game_rst got %b exp 00000", bus.game_rst); end
    tick();
    n_tests++; if (bus.rgb_out !== MENU_RGB) begin n_fail++; $display("FAIL midblank_rst_menu got %h exp %h", bus.rgb_out, MENU_RGB); end
    n_tests++; if (bus.game_rst !== 5'b0) begin n_fail++; $display("FAIL midblank_no_repulse got %b exp 00000", bus.game_rst); end
    n_tests++; if (bus.in_game !== 1'b0) begin n_fail++; $display("FAIL midblank_in_game got %b exp 0", bus.in_game); end
  endtask

  task automatic test_pix_en();
    bus.menu_rgb = 12'hF00;
    tick();
    n_tests++; if (bus.rgb_out !== 12'hF00) begin n_fail++; $display("FAIL pix_load got %h exp F00", bus.rgb_out); end
    bus.pix_en = 1'b0;
    bus.menu_rgb = 12'h0F0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (bus.rgb_out !== 12'hF00) begin n_fail++; $display("FAIL pix_hold[%0d] got %h exp F00", i, bus.rgb_out); end
    end
    bus.pix_en = 1'b1;
    tick();
    n_tests++; if (bus.rgb_out !== 12'h0F0) begin n_fail++; $display("FAIL pix_update got %h exp 0F0", bus.rgb_out); end
  endtask

  initial begin
    bus.pix_en      = 1'b1;
    bus.frame_start = 1'b0;
    bus.up_p        = 1'b0;
    bus.down_p      = 1'b0;
    bus.enter_p     = 1'b0;
    bus.exit_p      = 1'b0;
    bus.menu_rgb    = MENU_RGB;
    bus.menu_aud    = MENU_AUD;
    bus.game_rgb    = {12'h555, 12'h444, 12'h333, 12'h222, 12'h111};
    bus.game_aud    = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    test_reset();
    test_cursor();
    test_enter();
    test_exit();
    test_enter_down();
    test_frame_on_enter_rst();
    test_pix_en();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
